// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues instruction-memory reads through a
// req/valid handshake guarded by a watchdog, and exposes the IR fields to CONTROL.
module fetch_unit #(
  parameter int ADDR_W  = 5,
  parameter int OPC_W   = 3,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_en,
  input  logic              pc_load,
  input  logic              memIns_en,
  input  logic              halt,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_valid,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] operand,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_busy,
  output logic              fetch_done,
  output logic              fetch_err,
  output logic              halted
);

  // Eight bits covers the full legal TIMEOUT range.
  localparam int CNT_W = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [DATA_W-1:0]  ir;
  logic [CNT_W-1:0]   wd_count;
  logic               start_fetch;
  logic               capture;
  logic               timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start_fetch) state_next = S_WAIT;
      S_WAIT: if (capture || timeout) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // A halt arriving on the same edge as a fetch request wins, so the fetch never starts.
  always_comb begin
    start_fetch = 1'b0;
    capture     = 1'b0;
    timeout     = 1'b0;
    fetch_busy  = 1'b0;
    case (state)
      S_IDLE: start_fetch = memIns_en && !halted && !halt;
      S_WAIT: begin
        fetch_busy = 1'b1;
        capture    = imem_valid;
        timeout    = !imem_valid && (wd_count == CNT_W'(TIMEOUT - 1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      ir         <= '0;
      wd_count   <= '0;
      fetch_done <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      fetch_done <= 1'b0;
      if (start_fetch) begin
        imem_addr <= pc;
        imem_req  <= 1'b1;
        wd_count  <= '0;
        fetch_err <= 1'b0;
      end else if (capture) begin
        ir         <= imem_rdata;
        imem_req   <= 1'b0;
        fetch_done <= 1'b1;
      end else if (timeout) begin
        imem_req  <= 1'b0;
        fetch_err <= 1'b1;
      end else if (state == S_WAIT) begin
        wd_count <= wd_count + CNT_W'(1);
      end
    end
  end

  // PC moves independently of the FSM; an in-flight fetch already captured its address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= '0;
    end else if (!halted) begin
      if (pc_load) begin
        pc <= operand;
      end else if (pc_en) begin
        pc <= pc + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted <= 1'b0;
    end else if (halt) begin
      halted <= 1'b1;
    end
  end

  assign opcode  = ir[DATA_W-1 -: OPC_W];
  assign operand = ir[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: a vector table for the common
// handshake/PC paths plus hand-written timeout, reset and halt sequences.
module tb_fetch_unit;

  logic       clk;
  logic       rst;
  logic       pc_en;
  logic       pc_load;
  logic       memIns_en;
  logic       halt;
  logic [7:0] imem_rdata;
  logic       imem_valid;
  logic [4:0] imem_addr;
  logic       imem_req;
  logic [2:0] opcode;
  logic [4:0] operand;
  logic [4:0] pc;
  logic       fetch_busy;
  logic       fetch_done;
  logic       fetch_err;
  logic       halted;

  int num_checks = 0;
  int num_fails  = 0;

  fetch_unit #(.ADDR_W(5), .OPC_W(3), .DATA_W(8), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_en      (pc_en),
    .pc_load    (pc_load),
    .memIns_en  (memIns_en),
    .halt       (halt),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .opcode     (opcode),
    .operand    (operand),
    .pc         (pc),
    .fetch_busy (fetch_busy),
    .fetch_done (fetch_done),
    .fetch_err  (fetch_err),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pc_en;
    logic       pc_load;
    logic       mem_en;
    logic       halt;
    logic       valid;
    logic [7:0] rdata;
    logic [4:0] exp_pc;
    logic [4:0] exp_addr;
    logic       exp_req;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_err;
    logic [7:0] exp_ir;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic en, input logic ld, input logic me,
                              input logic valid, input logic [7:0] rdata,
                              input logic [4:0] e_pc, input logic [4:0] e_addr,
                              input logic e_req, input logic e_done,
                              input logic [7:0] e_ir);
    vec_t v;
    v.pc_en    = en;
    v.pc_load  = ld;
    v.mem_en   = me;
    v.halt     = 1'b0;
    v.valid    = valid;
    v.rdata    = rdata;
    v.exp_pc   = e_pc;
    v.exp_addr = e_addr;
    v.exp_req  = e_req;
    v.exp_busy = e_req;
    v.exp_done = e_done;
    v.exp_err  = 1'b0;
    v.exp_ir   = e_ir;
    return v;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive inputs, let one active edge happen, then leave us at the following falling edge.
  task automatic apply_stimulus(input logic en, input logic ld, input logic me,
                                input logic h, input logic valid, input logic [7:0] rdata);
    pc_en      = en;
    pc_load    = ld;
    memIns_en  = me;
    halt       = h;
    imem_valid = valid;
    imem_rdata = rdata;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_state(input string tag, input logic [4:0] e_pc, input logic [4:0] e_addr,
                             input logic e_req, input logic e_busy, input logic e_done,
                             input logic e_err, input logic [7:0] e_ir, input logic e_halted);
    check_output({tag, ".pc"}, int'(pc), int'(e_pc));
    check_output({tag, ".imem_addr"}, int'(imem_addr), int'(e_addr));
    check_output({tag, ".imem_req"}, int'(imem_req), int'(e_req));
    check_output({tag, ".fetch_busy"}, int'(fetch_busy), int'(e_busy));
    check_output({tag, ".fetch_done"}, int'(fetch_done), int'(e_done));
    check_output({tag, ".fetch_err"}, int'(fetch_err), int'(e_err));
    check_output({tag, ".opcode"}, int'(opcode), int'(e_ir[7:5]));
    check_output({tag, ".operand"}, int'(operand), int'(e_ir[4:0]));
    check_output({tag, ".halted"}, int'(halted), int'(e_halted));
  endtask

  task automatic do_reset();
    apply_stimulus(0, 0, 0, 0, 0, 8'h00);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Global guard so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation time limit reached");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    // Reset release, three pc_en pulses, then a 1-cycle-latency fetch of 8'hA7.
    vecs[0]  = mk(1, 0, 0, 0, 8'h00, 5'd1,  5'd0, 0, 0, 8'h00);
    vecs[1]  = mk(1, 0, 0, 0, 8'h00, 5'd2,  5'd0, 0, 0, 8'h00);
    vecs[2]  = mk(1, 0, 0, 0, 8'h00, 5'd3,  5'd0, 0, 0, 8'h00);
    vecs[3]  = mk(0, 0, 1, 0, 8'h00, 5'd3,  5'd3, 1, 0, 8'h00);
    vecs[4]  = mk(0, 0, 0, 1, 8'hA7, 5'd3,  5'd3, 0, 1, 8'hA7);
    vecs[5]  = mk(0, 0, 0, 0, 8'h00, 5'd3,  5'd3, 0, 0, 8'hA7);
    // Fetch 8'h5E (operand 1E), then pc_load+pc_en together, then wrap 1F->00.
    vecs[6]  = mk(0, 0, 1, 0, 8'h00, 5'd3,  5'd3, 1, 0, 8'hA7);
    vecs[7]  = mk(0, 0, 0, 1, 8'h5E, 5'd3,  5'd3, 0, 1, 8'h5E);
    vecs[8]  = mk(1, 1, 0, 0, 8'h00, 5'h1E, 5'd3, 0, 0, 8'h5E);
    vecs[9]  = mk(1, 0, 0, 0, 8'h00, 5'h1F, 5'd3, 0, 0, 8'h5E);
    vecs[10] = mk(1, 0, 0, 0, 8'h00, 5'h00, 5'd3, 0, 0, 8'h5E);
    // Fetch from address 0 with 5-cycle latency, pc_en toggling and memIns_en ignored in WAIT.
    vecs[11] = mk(0, 0, 1, 0, 8'h00, 5'd0,  5'd0, 1, 0, 8'h5E);
    vecs[12] = mk(1, 0, 0, 0, 8'h00, 5'd1,  5'd0, 1, 0, 8'h5E);
    vecs[13] = mk(0, 0, 1, 0, 8'h00, 5'd1,  5'd0, 1, 0, 8'h5E);
    vecs[14] = mk(1, 0, 0, 0, 8'h00, 5'd2,  5'd0, 1, 0, 8'h5E);
    vecs[15] = mk(0, 0, 0, 0, 8'h00, 5'd2,  5'd0, 1, 0, 8'h5E);
    vecs[16] = mk(1, 0, 0, 1, 8'h3C, 5'd3,  5'd0, 0, 1, 8'h3C);
    vecs[17] = mk(0, 0, 0, 0, 8'h00, 5'd3,  5'd0, 0, 0, 8'h3C);

    rst        = 1'b0;
    pc_en      = 1'b0;
    pc_load    = 1'b0;
    memIns_en  = 1'b0;
    halt       = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_state("reset", 5'd0, 5'd0, 0, 0, 0, 0, 8'h00, 0);
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i].pc_en, vecs[i].pc_load, vecs[i].mem_en, vecs[i].halt,
                     vecs[i].valid, vecs[i].rdata);
      check_state($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_addr, vecs[i].exp_req,
                  vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_ir, 1'b0);
    end

    // Watchdog: 16 WAIT edges without valid abort the fetch, IR stays 8'h3C.
    apply_stimulus(0, 0, 1, 0, 0, 8'h00);
    check_state("to_start", 5'd3, 5'd3, 1, 1, 0, 0, 8'h3C, 0);
    for (int i = 1; i <= 15; i++) begin
      apply_stimulus(0, 0, 0, 0, 0, 8'hFF);
    end
    check_output("to_edge15.imem_req", int'(imem_req), 1);
    check_output("to_edge15.fetch_err", int'(fetch_err), 0);
    apply_stimulus(0, 0, 0, 0, 0, 8'hFF);
    check_state("to_edge16", 5'd3, 5'd3, 0, 0, 0, 1, 8'h3C, 0);
    apply_stimulus(0, 0, 0, 0, 1, 8'hFF);
    check_state("to_idle_valid", 5'd3, 5'd3, 0, 0, 0, 1, 8'h3C, 0);
    apply_stimulus(0, 0, 1, 0, 0, 8'h00);
    check_state("to_restart", 5'd3, 5'd3, 1, 1, 0, 0, 8'h3C, 0);
    // Valid arriving on the very edge that would time out wins.
    for (int i = 1; i <= 15; i++) begin
      apply_stimulus(0, 0, 0, 0, 0, 8'h00);
    end
    apply_stimulus(0, 0, 0, 0, 1, 8'hE2);
    check_state("to_coincide", 5'd3, 5'd3, 0, 0, 1, 0, 8'hE2, 0);

    // Asynchronous reset between edges while a fetch is outstanding.
    apply_stimulus(0, 0, 1, 0, 0, 8'h00);
    check_state("ar_wait", 5'd3, 5'd3, 1, 1, 0, 0, 8'hE2, 0);
    #2 rst = 1'b0;
    #1;
    check_state("ar_immediate", 5'd0, 5'd0, 0, 0, 0, 0, 8'h00, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(0, 0, 0, 0, 1, 8'hFF);
    check_state("ar_late_valid", 5'd0, 5'd0, 0, 0, 0, 0, 8'h00, 0);

    // Halt raised mid-fetch: the fetch completes, then fetches and PC changes are frozen.
    apply_stimulus(1, 0, 0, 0, 0, 8'h00);
    apply_stimulus(1, 0, 0, 0, 0, 8'h00);
    apply_stimulus(0, 0, 1, 0, 0, 8'h00);
    check_state("h_start", 5'd2, 5'd2, 1, 1, 0, 0, 8'h00, 0);
    apply_stimulus(0, 0, 0, 1, 0, 8'h00);
    check_state("h_raise", 5'd2, 5'd2, 1, 1, 0, 0, 8'h00, 1);
    apply_stimulus(0, 0, 0, 0, 1, 8'h81);
    check_state("h_complete", 5'd2, 5'd2, 0, 0, 1, 0, 8'h81, 1);
    apply_stimulus(1, 0, 1, 0, 0, 8'h00);
    check_state("h_blocked_fetch", 5'd2, 5'd2, 0, 0, 0, 0, 8'h81, 1);
    apply_stimulus(0, 1, 0, 0, 0, 8'h00);
    check_state("h_blocked_load", 5'd2, 5'd2, 0, 0, 0, 0, 8'h81, 1);

    // Halt on the same edge as memIns_en in IDLE: no fetch starts.
    do_reset();
    apply_stimulus(0, 0, 1, 1, 0, 8'h00);
    check_state("h_same_edge", 5'd0, 5'd0, 0, 0, 0, 0, 8'h00, 1);
    apply_stimulus(0, 0, 1, 0, 1, 8'h55);
    check_state("h_same_after", 5'd0, 5'd0, 0, 0, 0, 0, 8'h00, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
